ctrl_word_skid_reg: RTL and testbench

- Registered pipeline stage between the instruction decoder (producer of the 39-bit packed control word) and the stage that unpacks it into fields.
- Provides a valid/ready handshake with a two-entry skid buffer, so the decoder can be back-pressured without a combinational ready path.
- Supports pipeline flush for branches and jumps, and counts back-pressure stall cycles for performance monitoring.
- Carries the instruction PC alongside the control word.

---
 rtl/ctrl_word_skid_reg_pkg.sv | 33 +++
 rtl/ctrl_word_skid_reg_sat_counter.sv | 20 ++
 rtl/ctrl_word_skid_reg.sv | 111 +++++++++++
 tb/tb_ctrl_word_skid_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_word_skid_reg_pkg.sv
// Shared definitions for the decoder-to-unpack control word pipeline stage.
// Holds the packed control word layout, the bubble encoding and the skid FSM states.
package ctrl_pkg;

  localparam int CTRL_W = 39;

  // All-zero word: gp_we=0, mem_wren=0, pc_mux_select=0 (sequential), so a bubble is harmless.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // Field layout of the packed control word, MSB first.
  typedef struct packed {
    logic [3:0] af;             // [38:35]
    logic       i;              // [34]
    logic       alu_mux_sel;    // [33]
    logic [2:0] shift_type;     // [32:30]
    logic [4:0] cad;            // [29:25]
    logic       gp_we;          // [24]
    logic [1:0] gp_mux_sel;     // [23:22]
    logic [3:0] bf;             // [21:18]
    logic [1:0] pc_mux_select;  // [17:16]
    logic       mem_wren;       // [15]
    logic [4:0] rs;             // [14:10]
    logic [4:0] rt;             // [9:5]
    logic [4:0] rd;             // [4:0]
  } ctrl_word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ctrl_word_skid_reg_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Counts one per enabled cycle; async active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_word_skid_reg.sv
// Registered valid/ready stage with a two-entry skid buffer carrying control word + PC.
// Latency 1; in_ready comes straight from a flop; flush empties the stage; stall cycles are counted.
module ctrl_word_skid_reg
  import ctrl_pkg::*;
#(
  parameter int CTRL_W = ctrl_pkg::CTRL_W,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_t       state;
  skid_state_t       state_nxt;
  logic              in_ready_q;
  logic              in_xfer;
  logic              out_xfer;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PC_W-1:0]   main_pc;
  logic [PC_W-1:0]   skid_pc;

  assign in_ready = in_ready_q;
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  // in_ready is precomputed from the next state so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (in_xfer) state_nxt = BUSY;
        BUSY: begin
          if (out_xfer && !in_xfer)      state_nxt = EMPTY;
          else if (in_xfer && !out_xfer) state_nxt = FULL;
        end
        FULL:    if (out_xfer) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid      = (state != EMPTY);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      load_main_in   = in_xfer && ((state == EMPTY) || ((state == BUSY) && out_xfer));
      load_skid      = in_xfer && (state == BUSY) && !out_xfer;
      load_main_skid = out_xfer && (state == FULL);
    end
    out_ctrl = out_valid ? main_ctrl : CTRL_W'(CTRL_NOP);
    out_pc   = out_valid ? main_pc : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_pc   <= '0;
      skid_ctrl <= '0;
      skid_pc   <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_pc   <= in_pc;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_pc   <= skid_pc;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_pc   <= in_pc;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_ctrl_word_skid_reg.sv
// Bench for ctrl_word_skid_reg: directed vector table, corner sequences, then random traffic vs a queue model.
module tb_ctrl_word_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [38:0] in_ctrl;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [38:0] out_ctrl;
  logic [31:0] out_pc;
  logic [15:0] stall_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [38:0] out_ctrl4;
  logic [31:0] out_pc4;
  logic [3:0]  stall_cnt4;

  ctrl_word_skid_reg #(.CTRL_W(39), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  ctrl_word_skid_reg #(.CTRL_W(39), .PC_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ctrl(out_ctrl4), .out_pc(out_pc4), .stall_cnt(stall_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: the stage is a FIFO of at most two {ctrl,pc} entries.
  logic [70:0] mq[$];
  int          m_stall;
  int          accepted;

  function automatic logic        m_ov();   return mq.size() > 0;                 endfunction
  function automatic logic        m_ir();   return mq.size() < 2;                 endfunction
  function automatic logic [38:0] m_ctrl(); return m_ov() ? mq[0][70:32] : 39'h0; endfunction
  function automatic logic [31:0] m_pc();   return m_ov() ? mq[0][31:0] : 32'h0;  endfunction
  function automatic int          m_st4();  return (m_stall > 15) ? 15 : m_stall; endfunction

  task automatic cycle();
    int  sz;
    bit  in_x;
    bit  out_x;
    sz    = mq.size();
    in_x  = in_valid && (sz < 2);
    out_x = (sz > 0) && out_ready;
    if ((sz > 0) && !out_ready && (m_stall < 65535)) m_stall++;
    if (flush) begin
      mq.delete();
    end else begin
      if (out_x) void'(mq.pop_front());
      if (in_x) begin
        mq.push_back({in_ctrl, in_pc});
        accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(m_ov()));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(m_ir()));
    chk({tag, "_out_ctrl"},  64'(out_ctrl),  64'(m_ctrl()));
    chk({tag, "_out_pc"},    64'(out_pc),    64'(m_pc()));
    chk({tag, "_stall16"},   64'(stall_cnt), 64'(m_stall));
    chk({tag, "_stall4"},    64'(stall_cnt4), 64'(m_st4()));
  endtask

  typedef struct {
    logic        iv;
    logic [38:0] ic;
    logic [31:0] ip;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic        eir;
    logic [38:0] ectrl;
    logic [31:0] epc;
    logic [15:0] estall;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [38:0] ic, logic [31:0] ip, logic ordy, logic fl,
                              logic eov, logic eir, logic [38:0] ectrl, logic [31:0] epc,
                              logic [15:0] estall);
    vec_t v;
    v = '{iv, ic, ip, ordy, fl, eov, eir, ectrl, epc, estall};
    return v;
  endfunction

  logic [38:0] w[11];
  logic [31:0] p[11];
  vec_t        tbl[16];
  logic [63:0] r;
  bit          done;

  initial begin
    w[0] = 39'h12_3456_789A;
    p[0] = 32'h0040_0000;
    for (int k = 1; k < 11; k++) begin
      w[k] = 39'(64'h0A5A_0000_0000 + 64'(k) * 64'h0101_0101);
      p[k] = 32'h0000_1000 + 32'(k) * 32'd4;
    end

    // Directed table: single word, back-pressure fill, drain order, flush from FULL and from BUSY.
    tbl[0]  = mk(1, w[0], p[0], 1, 0,  1, 1, w[0], p[0], 0);
    tbl[1]  = mk(0, 0,    0,    1, 0,  0, 1, 0,    0,    0);
    tbl[2]  = mk(1, w[1], p[1], 0, 0,  1, 1, w[1], p[1], 0);
    tbl[3]  = mk(1, w[2], p[2], 0, 0,  1, 0, w[1], p[1], 1);
    tbl[4]  = mk(1, w[3], p[3], 0, 0,  1, 0, w[1], p[1], 2);
    tbl[5]  = mk(1, w[3], p[3], 0, 0,  1, 0, w[1], p[1], 3);
    tbl[6]  = mk(1, w[3], p[3], 1, 0,  1, 1, w[2], p[2], 3);
    tbl[7]  = mk(1, w[3], p[3], 1, 0,  1, 1, w[3], p[3], 3);
    tbl[8]  = mk(0, 0,    0,    1, 0,  0, 1, 0,    0,    3);
    tbl[9]  = mk(1, w[4], p[4], 0, 0,  1, 1, w[4], p[4], 3);
    tbl[10] = mk(1, w[5], p[5], 0, 0,  1, 0, w[4], p[4], 4);
    tbl[11] = mk(1, w[6], p[6], 0, 1,  0, 1, 0,    0,    5);
    tbl[12] = mk(0, 0,    0,    1, 0,  0, 1, 0,    0,    5);
    tbl[13] = mk(1, w[7], p[7], 0, 0,  1, 1, w[7], p[7], 5);
    tbl[14] = mk(1, w[8], p[8], 1, 1,  0, 1, 0,    0,    5);
    tbl[15] = mk(0, 0,    0,    1, 0,  0, 1, 0,    0,    5);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_pc = '0; out_ready = 1'b0;
    m_stall = 0; accepted = 0;
    #3;
    chk("reset_out_valid", 64'(out_valid), 0);
    chk("reset_in_ready",  64'(in_ready),  1);
    chk("reset_out_ctrl",  64'(out_ctrl),  0);
    chk("reset_out_pc",    64'(out_pc),    0);
    chk("reset_stall",     64'(stall_cnt), 0);
    #9 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].iv; in_ctrl = tbl[i].ic; in_pc = tbl[i].ip;
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      cycle();
      flush = 1'b0;
      chk($sformatf("row%0d_out_valid", i), 64'(out_valid),  64'(tbl[i].eov));
      chk($sformatf("row%0d_in_ready", i),  64'(in_ready),   64'(tbl[i].eir));
      chk($sformatf("row%0d_out_ctrl", i),  64'(out_ctrl),   64'(tbl[i].ectrl));
      chk($sformatf("row%0d_out_pc", i),    64'(out_pc),     64'(tbl[i].epc));
      chk($sformatf("row%0d_stall16", i),   64'(stall_cnt),  64'(tbl[i].estall));
      chk($sformatf("row%0d_stall4", i),    64'(stall_cnt4), 64'(tbl[i].estall));
    end

    // Saturation: one word held under back-pressure for 20 cycles.
    in_valid = 1'b1; in_ctrl = w[9]; in_pc = p[9]; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    chk("sat_stall4",  64'(stall_cnt4), 15);
    chk("sat_stall16", 64'(stall_cnt),  25);
    chk_model("sat");

    // Fill to FULL, then assert reset between clock edges.
    in_valid = 1'b1; in_ctrl = w[10]; in_pc = p[10];
    cycle();
    in_valid = 1'b0;
    chk("full_in_ready", 64'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid),  0);
    chk("arst_in_ready",  64'(in_ready),   1);
    chk("arst_out_ctrl",  64'(out_ctrl),   0);
    chk("arst_out_pc",    64'(out_pc),     0);
    chk("arst_stall16",   64'(stall_cnt),  0);
    chk("arst_stall4",    64'(stall_cnt4), 0);
    mq.delete(); m_stall = 0; accepted = 0;
    #2 rst = 1'b0;

    // Random traffic: 100 accepted words, random back-pressure, occasional flush.
    done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((accepted >= 100) && (mq.size() == 0)) begin
        done = 1'b1;
        break;
      end
      r = {$urandom, $urandom};
      in_valid  = (accepted < 100) && ($urandom_range(0, 3) != 0);
      in_ctrl   = r[38:0];
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
      flush = 1'b0;
      chk_model($sformatf("rnd%0d", cyc));
    end
    chk("random_completed", 64'(done), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
